vme_rd_arbiter: RTL and testbench

Shares the single VME read master port among `NUM_CLIENTS` tensor loaders (input, weight, uop, accumulator loaders). It grants one read command at a time by round-robin and forwards it to the VME port. It then routes exactly `len+1` returning data beats back to the granted client before granting the next. It sits between the loader instances and the VME read port in the core.

---
 rtl/vme_rd_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/vme_rd_arbiter.sv | 117 +++++++++++
 tb/tb_vme_rd_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_rd_arb_pkg.sv
// Shared width defaults and FSM state encoding for the VME read arbiter.
package vme_rd_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int TAG_W  = 21;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: the first request at or above ptr wins,
// otherwise the lowest-numbered request wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic found;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    any = |req;
    if (any) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/vme_rd_arbiter.sv
// Shares one VME read port among several tensor loaders: one burst at a time,
// round-robin command grant, len+1 data beats routed back to the granted client.
module vme_rd_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = vme_rd_arb_pkg::ADDR_W,
  parameter int LEN_W       = vme_rd_arb_pkg::LEN_W,
  parameter int TAG_W       = vme_rd_arb_pkg::TAG_W,
  parameter int DATA_W      = vme_rd_arb_pkg::DATA_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        io_client_cmd_valid,
  output logic [NUM_CLIENTS-1:0]        io_client_cmd_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] io_client_cmd_bits_addr,
  input  logic [NUM_CLIENTS*LEN_W-1:0]  io_client_cmd_bits_len,
  input  logic [NUM_CLIENTS*TAG_W-1:0]  io_client_cmd_bits_tag,
  output logic [NUM_CLIENTS-1:0]        io_client_data_valid,
  input  logic [NUM_CLIENTS-1:0]        io_client_data_ready,
  output logic [DATA_W-1:0]             io_client_data_bits_data,
  output logic [TAG_W-1:0]              io_client_data_bits_tag,
  output logic                          io_vme_rd_cmd_valid,
  input  logic                          io_vme_rd_cmd_ready,
  output logic [ADDR_W-1:0]             io_vme_rd_cmd_bits_addr,
  output logic [LEN_W-1:0]              io_vme_rd_cmd_bits_len,
  output logic [TAG_W-1:0]              io_vme_rd_cmd_bits_tag,
  input  logic                          io_vme_rd_data_valid,
  output logic                          io_vme_rd_data_ready,
  input  logic [DATA_W-1:0]             io_vme_rd_data_bits_data,
  input  logic [TAG_W-1:0]              io_vme_rd_data_bits_tag,
  output logic                          io_busy
);
  import vme_rd_arb_pkg::*;

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  state_t               state, next_state;
  logic [IW-1:0]        ptr, sel, pick_idx;
  logic [NUM_CLIENTS-1:0] pick_grant;
  logic                 pick_any;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     len_q, cnt;
  logic [TAG_W-1:0]     tag_q;
  logic                 sel_ready, beat_fire;

  rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_rr (
    .req   (io_client_cmd_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_ready = io_client_data_ready[sel];
  assign beat_fire = (state == DATA) && io_vme_rd_data_valid && sel_ready;

  assign io_vme_rd_cmd_bits_addr  = addr_q;
  assign io_vme_rd_cmd_bits_len   = len_q;
  assign io_vme_rd_cmd_bits_tag   = tag_q;
  assign io_client_data_bits_data = io_vme_rd_data_bits_data;
  assign io_client_data_bits_tag  = io_vme_rd_data_bits_tag;
  assign io_busy                  = (state != IDLE);

  always_comb begin
    next_state           = state;
    io_client_cmd_ready  = '0;
    io_client_data_valid = '0;
    io_vme_rd_data_ready = 1'b0;
    io_vme_rd_cmd_valid  = 1'b0;
    case (state)
      IDLE: begin
        // Keep the grant quiet while reset holds the block, so no client sees a phantom accept.
        if (!reset) io_client_cmd_ready = pick_grant;
        if (pick_any) next_state = CMD;
      end
      CMD: begin
        io_vme_rd_cmd_valid = 1'b1;
        if (io_vme_rd_cmd_ready) next_state = DATA;
      end
      DATA: begin
        io_client_data_valid[sel] = io_vme_rd_data_valid;
        io_vme_rd_data_ready      = sel_ready;
        if (beat_fire && (cnt == '0)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      sel    <= '0;
      addr_q <= '0;
      len_q  <= '0;
      tag_q  <= '0;
      cnt    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (pick_any) begin
          sel    <= pick_idx;
          addr_q <= io_client_cmd_bits_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          len_q  <= io_client_cmd_bits_len[int'(pick_idx)*LEN_W +: LEN_W];
          tag_q  <= io_client_cmd_bits_tag[int'(pick_idx)*TAG_W +: TAG_W];
        end
        CMD: if (io_vme_rd_cmd_ready) cnt <= len_q;
        DATA: if (beat_fire) begin
          // Count down to zero rather than up to len, so len = all-ones never wraps.
          if (cnt == '0) ptr <= (sel == IW'(NUM_CLIENTS - 1)) ? '0 : sel + 1'b1;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vme_rd_arbiter.sv
// Self-checking bench for vme_rd_arbiter: directed scenarios plus randomized bursts
// checked against a round-robin/beat-count reference model.
module tb_vme_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int TW = 21;
  localparam int DW = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    io_client_cmd_valid = '0;
  logic [N-1:0]    io_client_cmd_ready;
  logic [N*AW-1:0] io_client_cmd_bits_addr = '0;
  logic [N*LW-1:0] io_client_cmd_bits_len = '0;
  logic [N*TW-1:0] io_client_cmd_bits_tag = '0;
  logic [N-1:0]    io_client_data_valid;
  logic [N-1:0]    io_client_data_ready = '0;
  logic [DW-1:0]   io_client_data_bits_data;
  logic [TW-1:0]   io_client_data_bits_tag;
  logic            io_vme_rd_cmd_valid;
  logic            io_vme_rd_cmd_ready = 1'b0;
  logic [AW-1:0]   io_vme_rd_cmd_bits_addr;
  logic [LW-1:0]   io_vme_rd_cmd_bits_len;
  logic [TW-1:0]   io_vme_rd_cmd_bits_tag;
  logic            io_vme_rd_data_valid = 1'b0;
  logic            io_vme_rd_data_ready;
  logic [DW-1:0]   io_vme_rd_data_bits_data = '0;
  logic [TW-1:0]   io_vme_rd_data_bits_tag = '0;
  logic            io_busy;

  logic [AW-1:0] c_addr [N];
  logic [LW-1:0] c_len  [N];
  logic [TW-1:0] c_tag  [N];

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  vme_rd_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .LEN_W(LW), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_client_cmd_valid      (io_client_cmd_valid),
    .io_client_cmd_ready      (io_client_cmd_ready),
    .io_client_cmd_bits_addr  (io_client_cmd_bits_addr),
    .io_client_cmd_bits_len   (io_client_cmd_bits_len),
    .io_client_cmd_bits_tag   (io_client_cmd_bits_tag),
    .io_client_data_valid     (io_client_data_valid),
    .io_client_data_ready     (io_client_data_ready),
    .io_client_data_bits_data (io_client_data_bits_data),
    .io_client_data_bits_tag  (io_client_data_bits_tag),
    .io_vme_rd_cmd_valid      (io_vme_rd_cmd_valid),
    .io_vme_rd_cmd_ready      (io_vme_rd_cmd_ready),
    .io_vme_rd_cmd_bits_addr  (io_vme_rd_cmd_bits_addr),
    .io_vme_rd_cmd_bits_len   (io_vme_rd_cmd_bits_len),
    .io_vme_rd_cmd_bits_tag   (io_vme_rd_cmd_bits_tag),
    .io_vme_rd_data_valid     (io_vme_rd_data_valid),
    .io_vme_rd_data_ready     (io_vme_rd_data_ready),
    .io_vme_rd_data_bits_data (io_vme_rd_data_bits_data),
    .io_vme_rd_data_bits_tag  (io_vme_rd_data_bits_tag),
    .io_busy                  (io_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      io_client_cmd_bits_addr[k*AW +: AW] = c_addr[k];
      io_client_cmd_bits_len[k*LW +: LW]  = c_len[k];
      io_client_cmd_bits_tag[k*TW +: TW]  = c_tag[k];
    end
  endtask

  // Reference: scan clients cyclically from the priority pointer.
  function automatic int model_pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     io_busy, 0);
    check({tag, "_cmdv"},     io_vme_rd_cmd_valid, 0);
    check({tag, "_addr"},     io_vme_rd_cmd_bits_addr, 0);
    check({tag, "_len"},      io_vme_rd_cmd_bits_len, 0);
    check({tag, "_tag"},      io_vme_rd_cmd_bits_tag, 0);
    check({tag, "_cdv"},      io_client_data_valid, 0);
    check({tag, "_vrdy"},     io_vme_rd_data_ready, 0);
    check({tag, "_crdy"},     io_client_cmd_ready, 0);
  endtask

  // rdy_mode: 0 random, 1 toggling 1,0,1,0..., 2 always ready (random mode also randomizes VME valid).
  task automatic run_txn(input logic [N-1:0] req, input int fixed_c, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic [TW-1:0] tg, input int len_max,
                         input int cmd_delay, input int rdy_mode, input int abort_beat);
    int w, beats, sent, cyc, budget;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    logic [TW-1:0] et;
    logic [N-1:0]  oh;
    logic          vld, rdy;
    logic [DW-1:0] d;
    logic [TW-1:0] rt;
    for (int k = 0; k < N; k++) begin
      c_addr[k] = $urandom;
      c_len[k]  = LW'($urandom_range(0, len_max));
      c_tag[k]  = TW'($urandom);
    end
    if (fixed_c >= 0) begin
      c_addr[fixed_c] = a;
      c_len[fixed_c]  = l;
      c_tag[fixed_c]  = tg;
    end
    @(negedge clock);
    io_client_cmd_valid  = req;
    drive_fields();
    io_vme_rd_cmd_ready  = 1'b0;
    io_vme_rd_data_valid = 1'b0;
    io_client_data_ready = '0;
    #1;
    w  = model_pick(req, m_ptr);
    ea = c_addr[w];
    el = c_len[w];
    et = c_tag[w];
    oh = '0;
    oh[w] = 1'b1;
    check("idle_busy", io_busy, 0);
    check("grant", io_client_cmd_ready, oh);
    check("cmd_not_yet", io_vme_rd_cmd_valid, 0);

    for (int dly = 0; dly <= cmd_delay; dly++) begin
      @(negedge clock);
      c_addr[w] = $urandom;
      c_len[w]  = LW'($urandom);
      c_tag[w]  = TW'($urandom);
      drive_fields();
      io_vme_rd_cmd_ready      = (dly == cmd_delay);
      io_vme_rd_data_valid     = 1'b1;
      io_vme_rd_data_bits_data = {$urandom, $urandom};
      io_client_data_ready     = '1;
      #1;
      check("cmd_valid", io_vme_rd_cmd_valid, 1);
      check("cmd_addr", io_vme_rd_cmd_bits_addr, ea);
      check("cmd_len", io_vme_rd_cmd_bits_len, el);
      check("cmd_tag", io_vme_rd_cmd_bits_tag, et);
      check("cmd_no_grant", io_client_cmd_ready, 0);
      check("cmd_no_vrdy", io_vme_rd_data_ready, 0);
      check("cmd_no_cdv", io_client_data_valid, 0);
      check("cmd_busy", io_busy, 1);
    end

    beats  = int'(el) + 1;
    sent   = 0;
    cyc    = 0;
    budget = 4 * beats + 50;
    while (sent < beats && cyc < budget) begin
      @(negedge clock);
      io_vme_rd_cmd_ready = 1'b0;
      vld = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rdy_mode == 1)      rdy = (cyc % 2 == 0);
      else if (rdy_mode == 2) rdy = 1'b1;
      else                    rdy = ($urandom_range(0, 3) != 0);
      d  = {$urandom, $urandom};
      rt = TW'($urandom);
      io_vme_rd_data_valid     = vld;
      io_vme_rd_data_bits_data = d;
      io_vme_rd_data_bits_tag  = rt;
      io_client_data_ready     = N'($urandom);
      io_client_data_ready[w]  = rdy;
      #1;
      oh = '0;
      oh[w] = vld;
      check("data_busy", io_busy, 1);
      check("data_cdv", io_client_data_valid, oh);
      check("data_vrdy", io_vme_rd_data_ready, rdy);
      check("data_bits", io_client_data_bits_data, d);
      check("data_tag", io_client_data_bits_tag, rt);
      check("data_no_grant", io_client_cmd_ready, 0);
      check("data_no_cmdv", io_vme_rd_cmd_valid, 0);
      if (vld && rdy) sent++;
      cyc++;
      if (abort_beat >= 0 && sent == abort_beat) begin
        #1;
        io_client_cmd_valid  = '1;
        io_vme_rd_data_valid = 1'b1;
        io_client_data_ready = '1;
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clock);
        reset = 1'b0;
        io_client_cmd_valid  = '0;
        io_vme_rd_data_valid = 1'b0;
        m_ptr = 0;
        return;
      end
    end
    check("beat_count", sent, beats);
    m_ptr = (w + 1) % N;

    @(negedge clock);
    io_client_cmd_valid  = '0;
    io_vme_rd_data_valid = 1'b1;
    io_client_data_ready = '1;
    #1;
    check("done_busy", io_busy, 0);
    check("done_vrdy", io_vme_rd_data_ready, 0);
    check("done_cdv", io_client_data_valid, 0);
    check("done_cmdv", io_vme_rd_cmd_valid, 0);
    io_vme_rd_data_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // All clients continuously requesting, single-beat bursts: order 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) run_txn(4'hF, -1, '0, '0, '0, 0, 0, 2, -1);

    // Single request from client 2, 4 beats.
    run_txn(4'b0100, 2, 32'h0000_1000, 8'd3, 21'h5, 0, 0, 2, -1);

    // VME command stalled for 5 cycles while others keep requesting.
    run_txn(4'b1011, -1, '0, '0, '0, 7, 5, 0, -1);

    // Client 1 data ready toggling.
    run_txn(4'b0010, 1, 32'hCAFE_0000, 8'd3, 21'h1A5A5, 0, 0, 1, -1);

    // Maximum length burst: 256 beats.
    run_txn(4'b1000, 3, 32'hDEAD_BEE0, 8'd255, 21'h1FFFFF, 0, 1, 0, -1);

    // Randomized traffic.
    for (int i = 0; i < 16; i++)
      run_txn(N'($urandom_range(1, 15)), -1, '0, '0, '0, 7, $urandom_range(0, 3), 0, -1);

    // Move the pointer off zero, then abort a burst by reset during beat 3 of 4.
    run_txn(4'b0001, -1, '0, '0, '0, 0, 0, 2, -1);
    run_txn(4'b0100, 2, 32'h0000_2000, 8'd3, 21'h7, 0, 0, 2, 2);
    // After reset, client 0 has first priority again.
    run_txn(4'hF, -1, '0, '0, '0, 2, 0, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
